// File: rtl/data_sram_resp.sv
// data_sram_resp: single-port 32-bit SRAM with a fixed-latency, in-order
// response queue. Reads snapshot the word when the request is accepted, and
// writes update the RAM on that same edge. Responses come back LATENCY cycles
// after acceptance, and at most QDEPTH requests can be outstanding.
// Optional feature: define DATA_SRAM_RESP_RANDOM_STALL_EN to add an LFSR
// that randomly withholds data_addr_ok.
module data_sram_resp #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2,
  parameter int QDEPTH     = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata
);

  // Four physical slots cover the largest legal QDEPTH. Only QDEPTH of them
  // are ever occupied.
  localparam int SLOTS = 4;
  localparam int CNT_W = 3;
  localparam int CD_W  = 3;
  localparam int WORDS = 1 << DEPTH_LOG2;
  // The entry's response cycle is the one in which its countdown reads zero.
  // Loading LATENCY-1 therefore answers exactly LATENCY cycles after the accept.
  localparam logic [CD_W-1:0] CD_INIT = CD_W'(LATENCY - 1);

  // Byte enables: bit 3 is the big-endian lane 0 (bits 31:24).
  // Misaligned halfword and word writes enable no lanes.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      2'd0:    be = 4'b1000 >> lo;
      2'd1:    be = lo[0] ? 4'b0000 : (lo[1] ? 4'b0011 : 4'b1100);
      default: be = (lo == 2'b00) ? 4'b1111 : 4'b0000;
    endcase
    return be;
  endfunction

  logic [31:0]           mem [WORDS];
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [31:0]           rd_word;
  logic [3:0]            wr_be;

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] ins_idx;
  logic             wr_q    [SLOTS];
  logic             wr_d    [SLOTS];
  logic [CD_W-1:0]  cd_q    [SLOTS];
  logic [CD_W-1:0]  cd_d    [SLOTS];
  logic [31:0]      rdata_q [SLOTS];
  logic [31:0]      rdata_d [SLOTS];

  logic retire;
  logic accept;
  logic has_room;
  logic stall;
  logic unused_addr_hi;

  // Address bits above the RAM index are ignored, so addresses wrap.
  assign unused_addr_hi = ^data_addr[31:DEPTH_LOG2+2];

  assign word_idx = data_addr[DEPTH_LOG2+1:2];
  assign rd_word  = mem[word_idx];
  assign wr_be    = byte_en(data_size, data_addr[1:0]);

  // The head retires in the cycle its countdown is zero.
  // A full queue may still accept in that same cycle.
  assign retire       = (count_q != '0) && (cd_q[0] == '0);
  assign has_room     = (count_q < CNT_W'(QDEPTH)) || retire;
  assign data_addr_ok = resetn && data_req && has_room && !stall;
  assign accept       = data_addr_ok;

  assign data_data_ok = retire;
  assign data_rdata   = (retire && !wr_q[0]) ? rdata_q[0] : 32'h0;

`ifdef DATA_SRAM_RESP_RANDOM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR with taps 16,14,13,11. It shifts toward the MSB every cycle.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // The LFSR restarts from a fixed seed so the stall pattern is repeatable.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr_q <= 16'hACE1;
    else         lfsr_q <= lfsr_d;
  end

  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  // Next queue state: shift out the retiring head, age every countdown,
  // then append the new entry behind the survivors.
  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      wr_d[i]    = wr_q[i];
      cd_d[i]    = cd_q[i];
      rdata_d[i] = rdata_q[i];
    end
    if (retire) begin
      for (int i = 0; i < SLOTS - 1; i++) begin
        wr_d[i]    = wr_q[i+1];
        cd_d[i]    = cd_q[i+1];
        rdata_d[i] = rdata_q[i+1];
      end
      wr_d[SLOTS-1]    = 1'b0;
      cd_d[SLOTS-1]    = '0;
      rdata_d[SLOTS-1] = 32'h0;
    end
    for (int i = 0; i < SLOTS; i++) begin
      if (cd_d[i] != '0) cd_d[i] = cd_d[i] - 1'b1;
    end
    ins_idx = retire ? (count_q - 1'b1) : count_q;
    if (accept) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (ins_idx == CNT_W'(i)) begin
          wr_d[i]    = data_wr;
          cd_d[i]    = CD_INIT;
          rdata_d[i] = data_wr ? 32'h0 : rd_word;
        end
      end
    end
    count_d = count_q;
    if (accept && !retire)      count_d = count_q + 1'b1;
    else if (!accept && retire) count_d = count_q - 1'b1;
  end

  // Queue control state. Reset drops every outstanding request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        wr_q[i] <= 1'b0;
        cd_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      for (int i = 0; i < SLOTS; i++) begin
        wr_q[i] <= wr_d[i];
        cd_q[i] <= cd_d[i];
      end
    end
  end

  // Snapshot payloads. They are only observed through valid entries.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SLOTS; i++) rdata_q[i] <= rdata_d[i];
  end

  // RAM write on the acceptance edge. The contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && data_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[word_idx][b*8 +: 8] <= data_wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp. A queue and array reference model predicts
// addr_ok, data_ok and rdata every cycle. Directed scenarios add checks
// against fixed constants.
module tb_data_sram_resp;
  localparam int DEPTH_LOG2 = 10;
  localparam int LATENCY    = 3;
  localparam int QDEPTH     = 2;

  logic        clk = 1'b1;
  logic        resetn;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  always #5 clk = ~clk;

  data_sram_resp #(.DEPTH_LOG2(DEPTH_LOG2), .LATENCY(LATENCY), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .resetn(resetn), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;

  resp_t       exp_q[$];
  logic [31:0] ref_mem [0:(1<<DEPTH_LOG2)-1];
  logic [31:0] resp_log[$];
  logic [15:0] lfsr_m = 16'hACE1;
  int          cyc = 0;
  int          checks = 0;
  int          passes = 0;
  int          dut_acc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, got, exp);
  endtask

  // Big-endian lanes: lane k occupies bits 31-8k down to 24-8k.
  function automatic logic [31:0] merge_write(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] size, input logic [1:0] lo);
    logic [31:0] r;
    r = old;
    for (int lane = 0; lane < 4; lane++) begin
      bit hit;
      case (size)
        2'd0:    hit = (lane == int'(lo));
        2'd1:    hit = (lo[0] == 1'b0) && ((lane / 2) == int'(lo[1]));
        default: hit = (lo == 2'b00);
      endcase
      if (hit) r[31-8*lane -: 8] = wd[31-8*lane -: 8];
    end
    return r;
  endfunction

  // One clock cycle: drive, predict, check at the negedge, then advance the model.
  task automatic cycle(input logic rst, input logic req, input logic wr, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata, output logic acc);
    logic        exp_ack, exp_dok;
    logic [31:0] exp_rd;
    resp_t       r;
    int          idx;
    resetn = rst; data_req = req; data_wr = wr; data_size = size;
    data_addr = addr; data_wdata = wdata;
    if (!rst) exp_q.delete();
    exp_dok = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    exp_rd  = exp_dok ? exp_q[0].data : 32'h0;
    exp_ack = rst && req && ((exp_q.size() < QDEPTH) || exp_dok);
`ifdef DATA_SRAM_RESP_RANDOM_STALL_EN
    if (lfsr_m[0]) exp_ack = 1'b0;
`endif
    @(negedge clk);
    chk("addr_ok", 32'(data_addr_ok), 32'(exp_ack));
    chk("data_ok", 32'(data_data_ok), 32'(exp_dok));
    chk("rdata", data_rdata, exp_rd);
    if (data_data_ok) resp_log.push_back(data_rdata);
    if (data_addr_ok) dut_acc++;
    if (exp_dok) void'(exp_q.pop_front());
    if (exp_ack) begin
      idx = int'(addr[DEPTH_LOG2+1:2]);
      r.due = cyc + LATENCY;
      if (wr) begin
        ref_mem[idx] = merge_write(ref_mem[idx], wdata, size, addr[1:0]);
        r.data = 32'h0;
      end else begin
        r.data = ref_mem[idx];
      end
      exp_q.push_back(r);
    end
    if (!rst) lfsr_m = 16'hACE1;
    else      lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    acc = exp_ack;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Hold a request until it is accepted, within a bounded number of cycles.
  task automatic issue(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      cycle(1'b1, 1'b1, wr, size, addr, wdata, acc);
      n++;
    end
    checks++;
    assert (acc) passes++;
    else $error("FAIL issue_bound: no accept within %0d cycles", n);
  endtask

  task automatic idle(input int n);
    logic acc;
    repeat (n) cycle(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, acc);
  endtask

  initial begin
    logic acc;
    int   d0;
    resetn = 1'b0; data_req = 1'b1; data_wr = 1'b0; data_size = 2'd0;
    data_addr = 32'h0; data_wdata = 32'h0;
    @(posedge clk);
    #1;
    // Reset held with a request pending: all outputs must stay low.
    cycle(1'b0, 1'b1, 1'b0, 2'd2, 32'h0, 32'h0, acc);
    cycle(1'b0, 1'b1, 1'b1, 2'd2, 32'h0, 32'h5555_5555, acc);

    // Preload the words used below. The first request lands on the first edge.
    for (int i = 0; i < 16; i++) issue(1'b1, 2'd2, 32'(i * 4), $urandom());
    issue(1'b1, 2'd2, 32'h104, 32'hCAFE_F00D);
    issue(1'b1, 2'd2, 32'h300, 32'h1111_1111);
    idle(LATENCY + 2);

    // Word write, then read-back on the next cycle.
    resp_log.delete();
    issue(1'b1, 2'd2, 32'h100, 32'h1234_5678);
    issue(1'b0, 2'd2, 32'h100, 32'h0);
    idle(LATENCY + 2);
    chk("wr_then_rd_count", 32'(resp_log.size()), 32'd2);
    chk("wr_then_rd_data", resp_log[1], 32'h1234_5678);

    // Byte and halfword merges into a zeroed word.
    resp_log.delete();
    issue(1'b1, 2'd2, 32'h200, 32'h0);
    issue(1'b1, 2'd0, 32'h201, 32'hABAB_ABAB);
    issue(1'b0, 2'd2, 32'h200, 32'h0);
    issue(1'b1, 2'd1, 32'h202, 32'hCDCD_CDCD);
    issue(1'b0, 2'd2, 32'h200, 32'h0);
    idle(LATENCY + 2);
    chk("byte_merge", resp_log[2], 32'h00AB_0000);
    chk("half_merge", resp_log[4], 32'h00AB_CDCD);

    // A read snapshot is unaffected by a write accepted one cycle later.
    resp_log.delete();
    issue(1'b0, 2'd2, 32'h300, 32'h0);
    issue(1'b1, 2'd2, 32'h300, 32'h2222_2222);
    idle(LATENCY + 2);
    chk("snapshot_rd", resp_log[0], 32'h1111_1111);
    chk("snapshot_wr_rdata", resp_log[1], 32'h0);

    // Misaligned word write is answered but leaves the word untouched.
    resp_log.delete();
    issue(1'b1, 2'd2, 32'h105, 32'hDEAD_BEEF);
    issue(1'b0, 2'd2, 32'h104, 32'h0);
    idle(LATENCY + 2);
    chk("misaligned_count", 32'(resp_log.size()), 32'd2);
    chk("misaligned_keep", resp_log[1], 32'hCAFE_F00D);

`ifndef DATA_SRAM_RESP_RANDOM_STALL_EN
    // Request held for 9 cycles with 2 slots and a 3-cycle latency.
    // Expected pattern: accept, accept, gap, repeated three times = 6 accepts.
    d0 = dut_acc;
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b1, 1'b0, 2'd2, 32'h10, 32'h0, acc);
    chk("held_accepts", 32'(dut_acc - d0), 32'd6);
    idle(LATENCY + 2);
`endif

    // Reset pulse drops outstanding reads. RAM contents survive.
    resp_log.delete();
    issue(1'b0, 2'd2, 32'h300, 32'h0);
    issue(1'b0, 2'd2, 32'h104, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 2'd2, 32'h300, 32'h0, acc);
    idle(LATENCY + 3);
    chk("reset_no_resp", 32'(resp_log.size()), 32'd0);
    issue(1'b0, 2'd2, 32'h300, 32'h0);
    idle(LATENCY + 2);
    chk("ram_retained", resp_log[0], 32'h2222_2222);

    // Random traffic over 16 preloaded words, with random high bits to exercise wrap.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
      cycle(1'b1, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            a, $urandom(), acc);
    end
    idle(LATENCY + 3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
